// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer between the core and the debug
// loader for the single-port VEDA data memory. Optional stats: DMEM_ARBITER_STATS_EN.
module dmem_arbiter #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_mode,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_mode,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_done,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
`ifdef DMEM_ARBITER_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [15:0]       cpu_cnt,
   output logic [15:0]       dbg_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_t;

   localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

   state_t              state_q;
   logic                id_q;
   logic                last_q;
   logic [2:0]          wcnt_q;
   logic                cpu_gnt_q;
   logic                cpu_done_q;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic                dbg_gnt_q;
   logic                dbg_done_q;
   logic [DATA_W-1:0]   dbg_rdata_q;
   logic                mem_en_q;
   logic                mem_mode_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_din_q;
   logic                busy_q;

   logic                any_req_d;
   logic                pick_dbg_d;
   logic                win_mode_d;
   logic [ADDR_W-1:0]   win_addr_d;
   logic [DATA_W-1:0]   win_wdata_d;

   // Winner selection: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      any_req_d  = cpu_req | dbg_req;
      pick_dbg_d = dbg_req & (~cpu_req | ~last_q);
      if (pick_dbg_d) begin
         win_mode_d  = dbg_mode;
         win_addr_d  = dbg_addr;
         win_wdata_d = dbg_wdata;
      end else begin
         win_mode_d  = cpu_mode;
         win_addr_d  = cpu_addr;
         win_wdata_d = cpu_wdata;
      end
   end

   // Transaction sequencer; every output is a register set on the state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         id_q        <= 1'b0;
         last_q      <= 1'b1;
         wcnt_q      <= '0;
         cpu_gnt_q   <= 1'b0;
         cpu_done_q  <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_gnt_q   <= 1'b0;
         dbg_done_q  <= 1'b0;
         dbg_rdata_q <= '0;
         mem_en_q    <= 1'b0;
         mem_mode_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         cpu_gnt_q  <= 1'b0;
         dbg_gnt_q  <= 1'b0;
         cpu_done_q <= 1'b0;
         dbg_done_q <= 1'b0;
         mem_en_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req_d) begin
                  id_q       <= pick_dbg_d;
                  last_q     <= pick_dbg_d;
                  mem_mode_q <= win_mode_d;
                  mem_addr_q <= win_addr_d;
                  mem_din_q  <= win_wdata_d;
                  mem_en_q   <= 1'b1;
                  cpu_gnt_q  <= ~pick_dbg_d;
                  dbg_gnt_q  <= pick_dbg_d;
                  busy_q     <= 1'b1;
                  state_q    <= ACCESS;
               end
            end
            ACCESS: begin
               if (mem_mode_q) begin
                  wcnt_q  <= WAIT_INIT;
                  state_q <= WAIT;
               end else begin
                  cpu_done_q <= ~id_q;
                  dbg_done_q <= id_q;
                  state_q    <= DONE;
               end
            end
            WAIT: begin
               if (wcnt_q == 3'd0) begin
                  if (id_q) begin
                     dbg_rdata_q <= mem_dout;
                  end else begin
                     cpu_rdata_q <= mem_dout;
                  end
                  cpu_done_q <= ~id_q;
                  dbg_done_q <= id_q;
                  state_q    <= DONE;
               end else begin
                  wcnt_q <= wcnt_q - 3'd1;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cpu_gnt   = cpu_gnt_q;
   assign cpu_done  = cpu_done_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_gnt   = dbg_gnt_q;
   assign dbg_done  = dbg_done_q;
   assign dbg_rdata = dbg_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_mode  = mem_mode_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign busy      = busy_q;

`ifdef DMEM_ARBITER_STATS_EN
   logic [15:0] cpu_cnt_q;
   logic [15:0] dbg_cnt_q;

   // Saturating completion counters; a clear beats a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_cnt_q <= '0;
         dbg_cnt_q <= '0;
      end else if (stat_clr) begin
         cpu_cnt_q <= '0;
         dbg_cnt_q <= '0;
      end else begin
         if (cpu_done_q && cpu_cnt_q != 16'hFFFF) begin
            cpu_cnt_q <= cpu_cnt_q + 16'd1;
         end
         if (dbg_done_q && dbg_cnt_q != 16'hFFFF) begin
            dbg_cnt_q <= dbg_cnt_q + 16'd1;
         end
      end
   end

   assign cpu_cnt = cpu_cnt_q;
   assign dbg_cnt = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter, one READ_LAT=1 instance
// and one READ_LAT=3 instance, each with a small latency memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        cpu_req = 0, cpu_mode = 0;
   logic [8:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_gnt, cpu_done;
   logic [31:0] cpu_rdata;
   logic        dbg_req = 0, dbg_mode = 0;
   logic [8:0]  dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic        dbg_gnt, dbg_done;
   logic [31:0] dbg_rdata;
   logic        mem_en, mem_mode, busy;
   logic [8:0]  mem_addr;
   logic [31:0] mem_din, mem_dout;
`ifdef DMEM_ARBITER_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] cpu_cnt, dbg_cnt;
`endif

   logic        c3_req = 0, c3_mode = 0;
   logic [8:0]  c3_addr = '0;
   logic [31:0] c3_wdata = '0;
   logic        c3_gnt, c3_done;
   logic [31:0] c3_rdata;
   logic        d3_req = 0, d3_mode = 0;
   logic [8:0]  d3_addr = '0;
   logic [31:0] d3_wdata = '0;
   logic        d3_gnt, d3_done;
   logic [31:0] d3_rdata;
   logic        m3_en, m3_mode, busy3;
   logic [8:0]  m3_addr;
   logic [31:0] m3_din, m3_dout;
`ifdef DMEM_ARBITER_STATS_EN
   logic        clr3 = 1'b0;
   logic [15:0] cc3, dc3;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .READ_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_mode(cpu_mode), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
      .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_mode(dbg_mode), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
      .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_mode(mem_mode), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
`ifdef DMEM_ARBITER_STATS_EN
      , .stat_clr(stat_clr), .cpu_cnt(cpu_cnt), .dbg_cnt(dbg_cnt)
`endif
   );

   dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .READ_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(c3_req), .cpu_mode(c3_mode), .cpu_addr(c3_addr),
      .cpu_wdata(c3_wdata), .cpu_gnt(c3_gnt), .cpu_done(c3_done),
      .cpu_rdata(c3_rdata),
      .dbg_req(d3_req), .dbg_mode(d3_mode), .dbg_addr(d3_addr),
      .dbg_wdata(d3_wdata), .dbg_gnt(d3_gnt), .dbg_done(d3_done),
      .dbg_rdata(d3_rdata),
      .mem_en(m3_en), .mem_mode(m3_mode), .mem_addr(m3_addr),
      .mem_din(m3_din), .mem_dout(m3_dout), .busy(busy3)
`ifdef DMEM_ARBITER_STATS_EN
      , .stat_clr(clr3), .cpu_cnt(cc3), .dbg_cnt(dc3)
`endif
   );

   // Memory content: 32'h12345678 at 9'h1FF, other words differ in low bits
   function automatic logic [31:0] mdata(input logic [8:0] a);
      return 32'h12345678 ^ {23'h0, a ^ 9'h1FF};
   endfunction

   // Latency-1 model: data visible for exactly one cycle, junk otherwise
   logic        v1 = 1'b0;
   logic [31:0] p1 = '0;
   always @(posedge clk) begin
      v1 <= mem_en && mem_mode;
      p1 <= mdata(mem_addr);
   end
   assign mem_dout = v1 ? p1 : 32'hBAD0BAD0;

   // Latency-3 model: three-stage pipeline
   logic        v3a = 0, v3b = 0, v3c = 0;
   logic [31:0] p3a = '0, p3b = '0, p3c = '0;
   always @(posedge clk) begin
      v3a <= m3_en && m3_mode;
      p3a <= mdata(m3_addr);
      v3b <= v3a;
      p3b <= p3a;
      v3c <= v3b;
      p3c <= p3b;
   end
   assign m3_dout = v3c ? p3c : 32'hBAD0BAD0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int dones;
      rst_n = 1'b0;
      step();
      step();
      total_cnt++;
      if ({cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_en, busy, mem_mode,
           mem_addr, mem_din, cpu_rdata, dbg_rdata} !== '0) begin
         $display("FAIL reset_state: got gnt/done/en/busy=%b%b%b%b%b%b mode=%b addr=%h din=%h rd=%h/%h want all 0",
                  cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_en, busy,
                  mem_mode, mem_addr, mem_din, cpu_rdata, dbg_rdata);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      cpu_req = 1'b1;
      cpu_mode = 1'b1;
      cpu_addr = 9'h010;
      step();
      cpu_req = 1'b0;
      total_cnt++;
      if ({cpu_gnt, mem_en, busy} !== 3'b111) begin
         $display("FAIL reset_pre_read: got gnt/en/busy=%b%b%b want 111",
                  cpu_gnt, mem_en, busy);
      end else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({mem_en, busy, cpu_done, dbg_done, cpu_gnt} !== 5'b0) begin
         $display("FAIL reset_async: got en/busy/cd/dd/gnt=%b%b%b%b%b want 00000",
                  mem_en, busy, cpu_done, dbg_done, cpu_gnt);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (cpu_done || dbg_done) dones++;
      end
      total_cnt++;
      if (dones !== 0 || busy !== 1'b0) begin
         $display("FAIL reset_no_done: got dones=%0d busy=%b want 0 0",
                  dones, busy);
      end else pass_cnt++;
   endtask

   task automatic test_single_write();
      cpu_req = 1'b1;
      cpu_mode = 1'b0;
      cpu_addr = 9'h023;
      cpu_wdata = 32'hDEADBEEF;
      step();
      cpu_req = 1'b0;
      cpu_wdata = 32'h0;
      total_cnt++;
      if ({cpu_gnt, dbg_gnt, mem_en, mem_mode, busy, cpu_done} !== 6'b101010
          || mem_addr !== 9'h023 || mem_din !== 32'hDEADBEEF) begin
         $display("FAIL wr_access: got gnt/dgnt/en/mode/busy/done=%b%b%b%b%b%b addr=%h din=%h want 101010 023 deadbeef",
                  cpu_gnt, dbg_gnt, mem_en, mem_mode, busy, cpu_done,
                  mem_addr, mem_din);
      end else pass_cnt++;
      step();
      total_cnt++;
      if ({cpu_gnt, mem_en, cpu_done, dbg_done, busy} !== 5'b00101) begin
         $display("FAIL wr_done: got gnt/en/cd/dd/busy=%b%b%b%b%b want 00101",
                  cpu_gnt, mem_en, cpu_done, dbg_done, busy);
      end else pass_cnt++;
      step();
      total_cnt++;
      if ({cpu_done, busy} !== 2'b00) begin
         $display("FAIL wr_idle: got done/busy=%b%b want 00", cpu_done, busy);
      end else pass_cnt++;
   endtask

   task automatic test_single_read();
      dbg_req = 1'b1;
      dbg_mode = 1'b1;
      dbg_addr = 9'h1FF;
      step();
      dbg_req = 1'b0;
      total_cnt++;
      if ({dbg_gnt, cpu_gnt, mem_en, mem_mode} !== 4'b1011
          || mem_addr !== 9'h1FF) begin
         $display("FAIL rd_access: got dgnt/cgnt/en/mode=%b%b%b%b addr=%h want 1011 1ff",
                  dbg_gnt, cpu_gnt, mem_en, mem_mode, mem_addr);
      end else pass_cnt++;
      step();
      total_cnt++;
      if ({dbg_done, mem_en, busy} !== 3'b001) begin
         $display("FAIL rd_wait: got done/en/busy=%b%b%b want 001",
                  dbg_done, mem_en, busy);
      end else pass_cnt++;
      step();
      total_cnt++;
      if ({dbg_done, cpu_done} !== 2'b10 || dbg_rdata !== 32'h12345678
          || cpu_rdata !== 32'h0) begin
         $display("FAIL rd_done: got dd/cd=%b%b drd=%h crd=%h want 10 12345678 00000000",
                  dbg_done, cpu_done, dbg_rdata, cpu_rdata);
      end else pass_cnt++;
      step();
      total_cnt++;
      if (dbg_done !== 1'b0 || dbg_rdata !== 32'h12345678) begin
         $display("FAIL rd_hold: got done=%b drd=%h want 0 12345678",
                  dbg_done, dbg_rdata);
      end else pass_cnt++;
   endtask

   task automatic test_contention();
      bit order[$];
      bit exp_order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int idle;
      rst_n = 1'b0;
      cpu_req = 1'b1;
      cpu_mode = 1'b0;
      cpu_addr = 9'h001;
      cpu_wdata = 32'h11111111;
      dbg_req = 1'b1;
      dbg_mode = 1'b0;
      dbg_addr = 9'h002;
      dbg_wdata = 32'h22222222;
      step();
      @(negedge clk);
      rst_n = 1'b1;
      idle = 0;
      for (int k = 0; k < 40 && order.size() < 4; k++) begin
         step();
         if (cpu_gnt || dbg_gnt) begin
            if (order.size() > 0) begin
               total_cnt++;
               if (idle !== 1) begin
                  $display("FAIL cont_gap%0d: got idle=%0d want 1",
                           order.size(), idle);
               end else pass_cnt++;
            end
            order.push_back(dbg_gnt);
            idle = 0;
            if (order.size() == 4) begin
               cpu_req = 1'b0;
               dbg_req = 1'b0;
            end
         end else if (!busy) begin
            idle++;
         end
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      total_cnt++;
      if (order.size() !== 4) begin
         $display("FAIL cont_count: got %0d grants want 4", order.size());
      end else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (i >= order.size() || order[i] !== exp_order[i]) begin
            $display("FAIL cont_order%0d: got %0d want %0d", i,
                     (i < order.size()) ? int'(order[i]) : -1,
                     int'(exp_order[i]));
         end else pass_cnt++;
      end
      step();
      step();
      step();
      total_cnt++;
      if (busy !== 1'b0) begin
         $display("FAIL cont_drain: got busy=%b want 0", busy);
      end else pass_cnt++;
   endtask

   task automatic test_read_lat3();
      int en_hi;
      int done_at;
      c3_req = 1'b1;
      c3_mode = 1'b1;
      c3_addr = 9'h005;
      step();
      c3_req = 1'b0;
      total_cnt++;
      if ({c3_gnt, m3_en, m3_mode} !== 3'b111 || m3_addr !== 9'h005) begin
         $display("FAIL lat3_access: got gnt/en/mode=%b%b%b addr=%h want 111 005",
                  c3_gnt, m3_en, m3_mode, m3_addr);
      end else pass_cnt++;
      en_hi = 0;
      done_at = -1;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (m3_en) en_hi++;
         if (c3_done && done_at < 0) done_at = k;
      end
      total_cnt++;
      if (en_hi !== 0) begin
         $display("FAIL lat3_en_once: got %0d extra en cycles want 0", en_hi);
      end else pass_cnt++;
      total_cnt++;
      if (done_at !== 4) begin
         $display("FAIL lat3_done: got done %0d cycles after gnt want 4",
                  done_at);
      end else pass_cnt++;
      total_cnt++;
      if (c3_rdata !== 32'h12345782) begin
         $display("FAIL lat3_data: got %h want 12345782", c3_rdata);
      end else pass_cnt++;
   endtask

`ifdef DMEM_ARBITER_STATS_EN
   task automatic do_txn(input bit who, input logic [8:0] a);
      if (who) begin
         dbg_req = 1'b1;
         dbg_mode = 1'b0;
         dbg_addr = a;
      end else begin
         cpu_req = 1'b1;
         cpu_mode = 1'b0;
         cpu_addr = a;
      end
      for (int i = 0; i < 10; i++) begin
         step();
         if (cpu_gnt || dbg_gnt) break;
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (cpu_done || dbg_done) break;
      end
      step();
   endtask

   task automatic test_stats();
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      total_cnt++;
      if (cpu_cnt !== 16'd0 || dbg_cnt !== 16'd0) begin
         $display("FAIL stat_clr0: got %0d/%0d want 0/0", cpu_cnt, dbg_cnt);
      end else pass_cnt++;
      do_txn(1'b0, 9'h030);
      do_txn(1'b1, 9'h031);
      do_txn(1'b0, 9'h032);
      do_txn(1'b1, 9'h033);
      do_txn(1'b0, 9'h034);
      total_cnt++;
      if (cpu_cnt !== 16'd3 || dbg_cnt !== 16'd2) begin
         $display("FAIL stat_count: got %0d/%0d want 3/2", cpu_cnt, dbg_cnt);
      end else pass_cnt++;
      cpu_req = 1'b1;
      cpu_mode = 1'b0;
      cpu_addr = 9'h040;
      step();
      cpu_req = 1'b0;
      step();
      stat_clr = 1'b1;
      total_cnt++;
      if (cpu_done !== 1'b1) begin
         $display("FAIL stat_done_align: got done=%b want 1", cpu_done);
      end else pass_cnt++;
      step();
      stat_clr = 1'b0;
      total_cnt++;
      if (cpu_cnt !== 16'd0 || dbg_cnt !== 16'd0) begin
         $display("FAIL stat_clr_wins: got %0d/%0d want 0/0", cpu_cnt, dbg_cnt);
      end else pass_cnt++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_contention();
      test_read_lat3();
`ifdef DMEM_ARBITER_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port VEDA data memory (512 x 32, 9-bit word address).
- Requester 0 is the core's load/store stage. Requester 1 is the host/debug loader, which preloads programs and data and dumps results.
- Arbitrates fairly with round-robin, drives the memory control signals, and returns read data with a one-cycle `done` pulse.
- Sits between the core datapath and VEDA_data; the core stalls its PC until `cpu_done`.

Parameters:
- ADDR_W, 9, memory word-address width.
- DATA_W, 32, data width.
- READ_LAT, 1, cycles from `mem_en` (read) until `mem_dout` is valid. Legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  core request; held until `cpu_gnt`.
- cpu_mode  input  1  1 = load (read), 0 = store (write).
- cpu_addr  input  ADDR_W  word address.
- cpu_wdata  input  DATA_W  store data.
- cpu_gnt  output  1  one-cycle pulse: request accepted.
- cpu_done  output  1  one-cycle pulse: access complete.
- cpu_rdata  output  DATA_W  load data; valid when `cpu_done`=1 and held until the next cpu load completes.
- dbg_req, dbg_mode, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata: same as the cpu_* ports, for the host/debug port.
- mem_en  output  1  memory enable.
- mem_mode  output  1  1 = read, 0 = write.
- mem_addr  output  ADDR_W  memory address.
- mem_din  output  DATA_W  memory write data.
- mem_dout  input  DATA_W  memory read data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-transaction):
  - State goes to IDLE.
  - All gnt, done, `mem_en` and `busy` outputs go to 0.
  - `mem_mode`, `mem_addr`, `mem_din`, `cpu_rdata` and `dbg_rdata` go to 0.
  - Round-robin pointer `last` is set to 1, so cpu wins the first tie.
  - An interrupted transaction is dropped and no done is issued.
- State machine: IDLE -> ACCESS -> (WAIT) -> DONE -> IDLE.
- IDLE:
  - Samples `cpu_req`/`dbg_req` at the clock edge.
  - If exactly one is high, that requester wins. If both are high, the requester other than `last` wins.
  - On a win: latch the winner id, mode, address and write data; set `last` to the winner; go to ACCESS.
  - With no request, remain in IDLE.
- ACCESS (1 cycle):
  - `mem_en`=1, with `mem_mode`/`mem_addr`/`mem_din` driven from the latched values.
  - Winner's gnt=1.
  - Write: next state DONE. Read: next state WAIT.
- WAIT:
  - Counter runs READ_LAT-1 further cycles with `mem_en`=0.
  - On the final cycle, capture `mem_dout` into the winner's rdata; go to DONE.
  - READ_LAT=1 means WAIT lasts one cycle and `mem_dout` is captured then.
- DONE (1 cycle): winner's done=1; next state IDLE.
- Latency, with request sampled in IDLE at edge N:
  - gnt and `mem_en` high during cycle N+1.
  - Write: done during cycle N+2.
  - Read: done during cycle N+2+READ_LAT.
- Throughput: one transaction per 3 (write) or 3+READ_LAT (read) cycles. No new request is sampled outside IDLE.
- Requester rules:
  - Fields must stay stable while req=1 and gnt has not been seen. After gnt they may change freely.
  - A request dropped before it is sampled is simply ignored.
  - A sampled transaction always completes, even if req falls.
  - Req still high during DONE is treated as a new request at the next IDLE sample.
- Loser's req stays pending; under continuous contention grants alternate cpu, dbg, cpu, …
- The losing requester's gnt, done and rdata are never touched.
- No address arithmetic; addresses pass through unchanged. Out-of-range addresses are impossible by width.

Optional Feature:
- Macro: DMEM_ARBITER_STATS_EN.
- With the macro defined:
  - Extra input `stat_clr` (1 bit) and outputs `cpu_cnt` and `dbg_cnt` (16 bits each).
  - Each counter increments on its requester's done and saturates at 16'hFFFF.
  - `stat_clr`=1 synchronously zeroes both counters; clear wins over a simultaneous increment.
  - Both counters reset to 0.
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: `rst_n`=0 asynchronously mid-read -> `mem_en`, `busy`, `cpu_done`, `dbg_done` are 0 immediately; no done follows after release.
- Single write: cpu_req=1, mode=0, addr=9'h023, wdata=32'hDEADBEEF at edge N -> `cpu_gnt` and `mem_en` in N+1 with mem_mode=0, mem_addr=9'h023, mem_din=32'hDEADBEEF; `cpu_done` in N+2.
- Single read: dbg_req=1, mode=1, addr=9'h1FF; model memory returns 32'h12345678 with READ_LAT=1 -> `dbg_done` in N+3 with dbg_rdata=32'h12345678; cpu_rdata unchanged.
- Contention: both req held continuously from reset for 4 transactions -> grant order cpu, dbg, cpu, dbg; `busy` is low for exactly one cycle between transactions.
- READ_LAT=3: cpu read -> `mem_en` high for one cycle only; `cpu_done` in N+5; data captured on the third cycle after `mem_en`.
- Stats (macro on): 3 cpu and 2 dbg transactions -> cpu_cnt=3, dbg_cnt=2; pulse `stat_clr` in the same cycle as a done -> both counters read 0.
